// File: rtl/sensor_conditioner.sv
// Six-channel switch conditioner: 2-flop synchronizers, a shared free-running tick,
// and per-channel tick-based debounce with one-cycle rise/fall strobes.
module sensor_conditioner #(
    parameter int unsigned TICK_DIV     = 100000,
    parameter int unsigned STABLE_TICKS = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] sw_raw,
    output logic [5:0] sw_clean,
    output logic [5:0] sw_rise,
    output logic [5:0] sw_fall,
    output logic       any_change,
    output logic       tick_1ms
);

    localparam int unsigned N_CH   = 6;
    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned STAB_W = $clog2(STABLE_TICKS) + 1;

    logic [N_CH-1:0]   sync_meta;
    logic [N_CH-1:0]   sync_q;
    logic [TICK_W-1:0] tick_cnt;
    logic [TICK_W-1:0] tick_cnt_d;
    logic              tick_d;
    logic [STAB_W-1:0] stab_q [N_CH];
    logic [STAB_W-1:0] stab_d [N_CH];
    logic [N_CH-1:0]   clean_d;
    logic [N_CH-1:0]   rise_d;
    logic [N_CH-1:0]   fall_d;

    // Tick strobe is registered from the next counter value so it is high
    // exactly while the counter sits at TICK_DIV-1.
    always_comb begin
        tick_cnt_d = '0;
        if (tick_cnt != TICK_W'(TICK_DIV - 1)) begin
            tick_cnt_d = tick_cnt + TICK_W'(1);
        end
        tick_d = (tick_cnt_d == TICK_W'(TICK_DIV - 1));
    end

    // Per-channel debounce: pending while sync differs from the clean level.
    always_comb begin
        clean_d = sw_clean;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            stab_d[i] = '0;
            if (sync_q[i] != sw_clean[i]) begin
                if (!tick_1ms) begin
                    stab_d[i] = stab_q[i];
                end else if (stab_q[i] == STAB_W'(STABLE_TICKS - 1)) begin
                    clean_d[i] = sync_q[i];
                    rise_d[i]  = sync_q[i];
                    fall_d[i]  = ~sync_q[i];
                end else begin
                    stab_d[i] = stab_q[i] + STAB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_meta <= '0;
            sync_q    <= '0;
            tick_cnt  <= '0;
            tick_1ms  <= 1'b0;
            sw_clean  <= '0;
            sw_rise   <= '0;
            sw_fall   <= '0;
            for (int i = 0; i < int'(N_CH); i++) begin
                stab_q[i] <= '0;
            end
        end else begin
            sync_meta <= sw_raw;
            sync_q    <= sync_meta;
            tick_cnt  <= tick_cnt_d;
            tick_1ms  <= tick_d;
            sw_clean  <= clean_d;
            sw_rise   <= rise_d;
            sw_fall   <= fall_d;
            for (int i = 0; i < int'(N_CH); i++) begin
                stab_q[i] <= stab_d[i];
            end
        end
    end

    assign any_change = |{sw_rise, sw_fall};

endmodule

// File: doc/sensor_conditioner.md
SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 Parameter TICK_DIV, default 100000, clock cycles per debounce tick (1 ms at 100 MHz); legal range >= 2.
REQ-002 Parameter STABLE_TICKS, default 10, number of consecutive ticks a changed input must hold before acceptance; legal range >= 1.
REQ-003 Port clock, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port sw_raw, input, 6 bits: asynchronous raw switches. Bit0 = ignition, bit1 = door_driver, bit2 = door_pass, bit3 = break, bit4 = hidden_sw, bit5 = reprogram.
REQ-006 Port sw_clean, output, 6 bits: debounced level per channel, same bit map as sw_raw.
REQ-007 Port sw_rise, output, 6 bits: one-cycle pulse per channel when sw_clean goes 0->1.
REQ-008 Port sw_fall, output, 6 bits: one-cycle pulse per channel when sw_clean goes 1->0.
REQ-009 Port any_change, output, 1 bit: OR of all sw_rise and sw_fall bits.
REQ-010 Port tick_1ms, output, 1 bit: debounce tick strobe, exported for downstream timers.

Function
REQ-011 Each sw_raw bit SHALL pass through a dedicated 2-flop synchronizer; sync value = sw_raw delayed 2 cycles.
REQ-012 Tick counter SHALL count 0..TICK_DIV-1 and wrap to 0; tick_1ms = 1 exactly in cycles where the counter = TICK_DIV-1.
REQ-013 Tick counter SHALL free-run, independent of channel activity.
REQ-014 Each channel SHALL have its own stability counter, width clog2(STABLE_TICKS)+1.
REQ-015 Channel in state IDLE (sync == sw_clean): stability counter held at 0.
REQ-016 Channel in state PENDING (sync != sw_clean), on a cycle with tick_1ms = 1 and counter < STABLE_TICKS-1: counter increments by 1.
REQ-017 In PENDING, on a cycle with tick_1ms = 1 and counter = STABLE_TICKS-1: commit. Next cycle sw_clean bit = sync, counter = 0, and the matching sw_rise or sw_fall bit = 1 for exactly one cycle.
REQ-018 Bounce: any cycle with sync == sw_clean SHALL return the counter to 0 and cancel PENDING with no pulse, including the cycle before a would-be commit.
REQ-019 Acceptance latency from sync change to sw_clean change SHALL be between (STABLE_TICKS-1)*TICK_DIV+1 and STABLE_TICKS*TICK_DIV cycles, for a stable input.
REQ-020 Channels SHALL be independent; simultaneous commits on several channels SHALL produce simultaneous pulses.
REQ-021 sw_rise and sw_fall SHALL never both be 1 on the same bit; no pulse SHALL be produced without a sw_clean change.
REQ-022 any_change SHALL be combinational from the registered pulse vectors, with zero added latency.
REQ-023 With STABLE_TICKS = 1, commit SHALL occur on the first tick observed in PENDING.

Reset
REQ-024 While reset = 1 at a clock edge: synchronizer flops, tick counter, stability counters, sw_clean, sw_rise and sw_fall SHALL all load 0; tick_1ms = 0 and any_change = 0.
REQ-025 Reset SHALL take priority over any commit or tick in the same cycle.
REQ-026 Inputs held high through reset release SHALL be accepted as a normal rise after the debounce interval; no pulse is suppressed or invented.
REQ-027 Reset mid-PENDING SHALL discard the pending change; after release, debounce restarts from a zero count.

Verification (TICK_DIV = 4, STABLE_TICKS = 3 unless stated)
REQ-028 Free-run after reset -> tick_1ms high on cycles 4, 8, 12, ... counted from the first cycle after release, one cycle wide.
REQ-029 sw_raw[0] 0->1, held -> sw_clean[0] rises 11..15 cycles after the raw edge; sw_rise[0] and any_change pulse once in that cycle; sw_fall = 0.
REQ-030 sw_raw[1] glitch high for 6 cycles, then low -> sw_clean[1] stays 0; no pulse on any output.
REQ-031 sw_raw = 6'b111111 applied in one cycle -> all six sw_rise bits pulse in the same cycle; later release to 0 -> all six sw_fall bits pulse together.
REQ-032 Reset asserted 8 cycles after a sw_raw[5] rise, held 2 cycles, input kept high -> sw_clean[5] = 0 during reset; rises only after a full new debounce interval measured from release.
REQ-033 STABLE_TICKS = 1, TICK_DIV = 2, toggle sw_raw[3] every 10 cycles -> every toggle is accepted, with alternating sw_rise[3] and sw_fall[3] pulses.
